// File: rtl/sram_pkg.sv
// Shared types, constants and the lane-mask helper for the 1W1R SRAM model.
package sram_pkg;

  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  localparam int RD_FIRST       = 0;
  localparam int WR_FIRST       = 1;
  localparam int MAX_DATA_WIDTH = 1024;
  localparam int MAX_LANES      = MAX_DATA_WIDTH;
  localparam int IDX_W          = $clog2(MAX_DATA_WIDTH);

  // Widen a per-lane write mask into a per-bit mask; callers truncate to their word width.
  function automatic logic [MAX_DATA_WIDTH-1:0] expand_wmask(input logic [MAX_LANES-1:0] mask,
                                                             input int unsigned lane_bits);
    logic [MAX_DATA_WIDTH-1:0] bits;
    bits = {MAX_DATA_WIDTH{1'b0}};
    if (lane_bits != 32'd0) begin
      for (int unsigned i = 0; i < MAX_DATA_WIDTH; i++) begin
        bits[IDX_W'(i)] = mask[IDX_W'(i / lane_bits)];
      end
    end else begin
      bits = {MAX_DATA_WIDTH{1'b0}};
    end
    return bits;
  endfunction

endpackage

// File: rtl/sram_1w1r_param_if.sv
// Request/response bundle between an SRAM user (master) and the SRAM model (slave).
interface sram_1w1r_param_if #(
  parameter int DATA_WIDTH = 136,
  parameter int ADDR_WIDTH = 10,
  parameter int WRITE_SIZE = 17
);
  localparam int NUM_WMASKS = DATA_WIDTH / WRITE_SIZE;

  logic                  busy;
  logic                  csb0;
  logic [NUM_WMASKS-1:0] wmask0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] din0;
  logic                  csb1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] dout1;
  logic                  dout1_valid;
  logic [15:0]           coll_cnt;

  modport master (
    output csb0, wmask0, addr0, din0, csb1, addr1,
    input  busy, dout1, dout1_valid, coll_cnt
  );

  modport slave (
    input  csb0, wmask0, addr0, din0, csb1, addr1,
    output busy, dout1, dout1_valid, coll_cnt
  );
endinterface

// File: rtl/sram_rd_pipe.sv
// Data+valid delay line of DEPTH stages; data in each stage only advances with its valid.
module sram_rd_pipe #(
  parameter int WIDTH = 136,
  parameter int DEPTH = 1
) (
  input  logic             clk0,
  input  logic             rst0,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_clk_rst_s;
    assign unused_clk_rst_s = clk0 ^ rst0;
    assign out_data  = in_data;
    assign out_valid = in_valid;
  end else begin : g_stages
    logic [WIDTH-1:0] data_r [DEPTH];
    logic [DEPTH-1:0] valid_r;

    always_ff @(posedge clk0 or posedge rst0) begin
      if (rst0) begin
        for (int i = 0; i < DEPTH; i++) data_r[i] <= {WIDTH{1'b0}};
        valid_r <= {DEPTH{1'b0}};
      end else begin
        valid_r[0] <= in_valid;
        if (in_valid) data_r[0] <= in_data;
        for (int i = 1; i < DEPTH; i++) begin
          valid_r[i] <= valid_r[i-1];
          if (valid_r[i-1]) data_r[i] <= data_r[i-1];
        end
      end
    end

    assign out_data  = data_r[DEPTH-1];
    assign out_valid = valid_r[DEPTH-1];
  end

endmodule

// File: rtl/sram_1w1r_param.sv
// 1W1R behavioural SRAM with post-reset clear FSM, read/write collision policy and
// latency 1/2 read path. Define SRAM_COLL_CNT_EN to build the collision counter.
module sram_1w1r_param
  import sram_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 136,
  parameter int                    ADDR_WIDTH   = 10,
  parameter int                    WRITE_SIZE   = 17,
  parameter int                    READ_LATENCY = 1,
  parameter int                    RD_WR_MODE   = RD_FIRST,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = {DATA_WIDTH{1'b0}}
) (
  input logic             clk0,
  input logic             rst0,
  sram_1w1r_param_if.slave bus
);

  localparam int NUM_WMASKS = DATA_WIDTH / WRITE_SIZE;
  localparam int RAM_DEPTH  = 1 << ADDR_WIDTH;
  localparam int PIPE_DEPTH = (READ_LATENCY == 2) ? 1 : 0;

  if ((DATA_WIDTH % WRITE_SIZE) != 0) begin : g_bad_write_size
    $error("DATA_WIDTH must be a multiple of WRITE_SIZE");
  end
  if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_latency
    $error("READ_LATENCY must be 1 or 2");
  end
  if (DATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad_width
    $error("DATA_WIDTH exceeds MAX_DATA_WIDTH");
  end

  state_e                state_r, state_nxt_s;
  logic [ADDR_WIDTH-1:0] ptr_r, ptr_nxt_s;
  logic [DATA_WIDTH-1:0] mem_r [RAM_DEPTH];

  logic                  run_s, wr_en_s, rd_en_s, coll_s;
  logic [DATA_WIDTH-1:0] bit_mask_s, wr_word_s, rd_word_s;
  logic [DATA_WIDTH-1:0] s0_data_r, pipe_data_s, dout_r;
  logic                  s0_valid_r, pipe_valid_s, dout_valid_r;

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      state_r <= S_INIT;
      ptr_r   <= {ADDR_WIDTH{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
    end
  end

  // Clear walks every address once, then hands over to normal operation.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    case (state_r)
      S_INIT: begin
        ptr_nxt_s = ptr_r + ADDR_WIDTH'(1'b1);
        if (ptr_r == ADDR_WIDTH'(RAM_DEPTH - 1)) begin
          state_nxt_s = S_RUN;
        end else begin
          state_nxt_s = S_INIT;
        end
      end
      S_RUN: begin
        state_nxt_s = S_RUN;
        ptr_nxt_s   = {ADDR_WIDTH{1'b0}};
      end
      default: begin
        state_nxt_s = S_INIT;
        ptr_nxt_s   = {ADDR_WIDTH{1'b0}};
      end
    endcase
  end

  assign run_s      = (state_r == S_RUN);
  assign wr_en_s    = run_s & ~bus.csb0 & (|bus.wmask0);
  assign rd_en_s    = run_s & ~bus.csb1;
  assign coll_s     = wr_en_s & rd_en_s & (bus.addr0 == bus.addr1);
  assign bit_mask_s = DATA_WIDTH'(expand_wmask(MAX_LANES'(bus.wmask0), WRITE_SIZE));
  assign wr_word_s  = (mem_r[bus.addr0] & ~bit_mask_s) | (bus.din0 & bit_mask_s);

  // On a collision wr_word_s is exactly the merged word the write-first policy returns.
  always_comb begin
    rd_word_s = mem_r[bus.addr1];
    if (coll_s && (RD_WR_MODE == WR_FIRST)) begin
      rd_word_s = wr_word_s;
    end else begin
      rd_word_s = mem_r[bus.addr1];
    end
  end

  always_ff @(posedge clk0) begin
    if (state_r == S_INIT) begin
      mem_r[ptr_r] <= INIT_VALUE;
    end else if (wr_en_s) begin
      mem_r[bus.addr0] <= wr_word_s;
    end
  end

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      s0_valid_r <= 1'b0;
      s0_data_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      s0_valid_r <= rd_en_s;
      if (rd_en_s) s0_data_r <= rd_word_s;
    end
  end

  sram_rd_pipe #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (PIPE_DEPTH)
  ) u_rd_pipe (
    .clk0      (clk0),
    .rst0      (rst0),
    .in_data   (s0_data_r),
    .in_valid  (s0_valid_r),
    .out_data  (pipe_data_s),
    .out_valid (pipe_valid_s)
  );

  // Output stage holds the last returned word between reads.
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      dout_r       <= {DATA_WIDTH{1'b0}};
      dout_valid_r <= 1'b0;
    end else begin
      dout_valid_r <= pipe_valid_s;
      if (pipe_valid_s) dout_r <= pipe_data_s;
    end
  end

  assign bus.busy        = ~run_s;
  assign bus.dout1       = dout_r;
  assign bus.dout1_valid = dout_valid_r;

`ifdef SRAM_COLL_CNT_EN
  logic [15:0] coll_cnt_r;

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      coll_cnt_r <= 16'h0000;
    end else if (coll_s && (coll_cnt_r != 16'hFFFF)) begin
      coll_cnt_r <= coll_cnt_r + 16'h0001;
    end
  end

  assign bus.coll_cnt = coll_cnt_r;
`else
  assign bus.coll_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_sram_1w1r_param.sv
// Bench: a read-first/latency-1 and a write-first/latency-2 instance driven in lockstep
// and compared against an array-and-queue reference model.
module tb_sram_1w1r_param;
  localparam int DW = 136;
  localparam int AW = 4;
  localparam int WS = 17;
  localparam int NL = DW / WS;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          csb0 = 1'b1, csb1 = 1'b1;
  logic [NL-1:0] wmask0 = '0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] din0 = '0;

  sram_1w1r_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WRITE_SIZE(WS)) ifa ();
  sram_1w1r_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WRITE_SIZE(WS)) ifb ();

  assign ifa.csb0 = csb0;  assign ifa.wmask0 = wmask0; assign ifa.addr0 = addr0;
  assign ifa.din0 = din0;  assign ifa.csb1 = csb1;     assign ifa.addr1 = addr1;
  assign ifb.csb0 = csb0;  assign ifb.wmask0 = wmask0; assign ifb.addr0 = addr0;
  assign ifb.din0 = din0;  assign ifb.csb1 = csb1;     assign ifb.addr1 = addr1;

  sram_1w1r_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WRITE_SIZE(WS), .READ_LATENCY(1),
                    .RD_WR_MODE(0), .INIT_VALUE({DW{1'b0}}))
    dut_a (.clk0(clk), .rst0(rst), .bus(ifa));
  sram_1w1r_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WRITE_SIZE(WS), .READ_LATENCY(2),
                    .RD_WR_MODE(1), .INIT_VALUE({DW{1'b0}}))
    dut_b (.clk0(clk), .rst0(rst), .bus(ifb));

  typedef struct { int due; logic [DW-1:0] data; } rd_t;

  logic [DW-1:0] mem_m [DEPTH];
  rd_t           qa[$], qb[$];
  logic [DW-1:0] dout_a_m, dout_b_m;
  logic          val_a_m, val_b_m;
  int            busy_left, cyc, coll_m;
  int            errors = 0, checks = 0;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [NL-1:0] m);
    for (int i = 0; i < NL; i++) if (m[i]) old[i*WS +: WS] = d[i*WS +: WS];
    return old;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    qa.delete(); qb.delete();
    dout_a_m = '0; dout_b_m = '0; val_a_m = 1'b0; val_b_m = 1'b0;
    busy_left = DEPTH; coll_m = 0;
  endtask

  task automatic model_edge();
    logic [DW-1:0] old_w;
    cyc++;
    if (busy_left > 0) begin
      busy_left--;
    end else begin
      if (!csb1) begin
        old_w = mem_m[addr1];
        qa.push_back('{due: cyc + 1, data: old_w});
        if (!csb0 && addr0 == addr1) qb.push_back('{due: cyc + 2, data: merge(old_w, din0, wmask0)});
        else                         qb.push_back('{due: cyc + 2, data: old_w});
        if (!csb0 && addr0 == addr1 && wmask0 != '0 && coll_m < 65535) coll_m++;
      end
      if (!csb0) mem_m[addr0] = merge(mem_m[addr0], din0, wmask0);
    end
    val_a_m = 1'b0; val_b_m = 1'b0;
    if (qa.size() > 0 && qa[0].due == cyc) begin val_a_m = 1'b1; dout_a_m = qa[0].data; void'(qa.pop_front()); end
    if (qb.size() > 0 && qb[0].due == cyc) begin val_b_m = 1'b1; dout_b_m = qb[0].data; void'(qb.pop_front()); end
  endtask

  task automatic check_all();
    int coll_exp;
`ifdef SRAM_COLL_CNT_EN
    coll_exp = coll_m;
`else
    coll_exp = 0;
`endif
    chk("a_busy",  DW'(ifa.busy),        DW'(busy_left > 0));
    chk("b_busy",  DW'(ifb.busy),        DW'(busy_left > 0));
    chk("a_valid", DW'(ifa.dout1_valid), DW'(val_a_m));
    chk("b_valid", DW'(ifb.dout1_valid), DW'(val_b_m));
    chk("a_dout",  ifa.dout1,            dout_a_m);
    chk("b_dout",  ifb.dout1,            dout_b_m);
    chk("a_coll",  DW'(ifa.coll_cnt),    DW'(coll_exp));
    chk("b_coll",  DW'(ifb.coll_cnt),    DW'(coll_exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst) model_edge();
    check_all();
  endtask

  task automatic rand_inputs(input int amax);
    csb0   = 1'($urandom_range(0, 1));
    csb1   = 1'($urandom_range(0, 1));
    addr0  = AW'($urandom_range(0, amax));
    addr1  = AW'($urandom_range(0, amax));
    wmask0 = NL'($urandom());
    din0   = DW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
  endtask

  logic [DW-1:0] ones, pat;
  int            coll_one;

  initial begin
    ones = {DW{1'b1}};
    pat  = '0;
    pat[16:0]  = {17{1'b1}};
    pat[50:34] = {17{1'b1}};
`ifdef SRAM_COLL_CNT_EN
    coll_one = 1;
`else
    coll_one = 0;
`endif
    cyc = 0;
    model_reset();

    // Reset state, then clear-FSM busy window of exactly DEPTH cycles
    #1 rst = 1'b1;
    #1 check_all();
    repeat (2) tick();
    rst = 1'b0;
    model_reset();
    repeat (DEPTH) tick();

    // Never-written word reads as INIT_VALUE
    csb1 = 1'b0; addr1 = AW'(5);
    tick();
    csb1 = 1'b1;
    repeat (2) tick();
    chk("s1_init_word", ifb.dout1, '0);

    // Partial lane write
    csb0 = 1'b0; addr0 = AW'(3); din0 = ones; wmask0 = NL'(8'b0000_0101);
    tick();
    csb0 = 1'b1; csb1 = 1'b0; addr1 = AW'(3);
    tick();
    csb1 = 1'b1;
    tick();
    chk("s2_lanes_a", ifa.dout1, pat);
    tick();
    chk("s2_lanes_b", ifb.dout1, pat);

    // Same-address collision: read-first vs write-first
    csb0 = 1'b0; csb1 = 1'b0; addr0 = AW'(7); addr1 = AW'(7); din0 = ones; wmask0 = NL'(8'hFF);
    tick();
    csb0 = 1'b1; csb1 = 1'b1;
    tick();
    chk("s3_rd_first", ifa.dout1, '0);
    tick();
    chk("s3_wr_first", ifb.dout1, ones);
    chk("s3_coll", DW'(ifa.coll_cnt), DW'(coll_one));

    // Back-to-back reads in order
    for (int i = 0; i < 3; i++) begin
      csb0 = 1'b0; addr0 = AW'(i); wmask0 = NL'(8'hFF);
      din0 = DW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
      tick();
    end
    csb0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      csb1 = 1'b0; addr1 = AW'(i);
      tick();
    end
    csb1 = 1'b1;
    repeat (3) tick();

    // Randomised traffic over a narrow address range to provoke collisions
    for (int n = 0; n < 400; n++) begin
      rand_inputs((n < 200) ? 3 : DEPTH - 1);
      tick();
    end
    csb0 = 1'b1; csb1 = 1'b1;
    repeat (3) tick();

    // Reset with a read in flight, requests ignored during the restarted clear
    csb1 = 1'b0; addr1 = AW'(3);
    tick();
    csb1 = 1'b1;
    rst = 1'b1;
    model_reset();
    #1 check_all();
    chk("s5_dout_zero", ifa.dout1, '0);
    repeat (2) tick();
    rst = 1'b0;
    model_reset();
    for (int n = 0; n < DEPTH; n++) begin
      rand_inputs(DEPTH - 1);
      tick();
    end
    csb0 = 1'b1; csb1 = 1'b0; addr1 = AW'(3);
    tick();
    csb1 = 1'b1;
    repeat (2) tick();
    chk("s5_cleared", ifb.dout1, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
